lbist_engine: RTL and testbench
===============================

// Module: lbist_engine
// PURPOSE
//  Parametrised logic-BIST engine for the combinational benchmark netlists used by the ATPG flow.
//  A Galois LFSR drives pseudo-random patterns onto the circuit-under-test (CUT) inputs.
//  A MISR compacts the CUT responses into a signature, which is compared against a golden value.
//  The CUT is instantiated alongside this block; this block never contains CUT logic.
// PARAMETERS
//  PI_W       6        CUT primary-input count; must be <= LFSR_W
//  PO_W       1        CUT primary-output count; must be <= MISR_W
//  LFSR_W     16       pattern-generator width
//  LFSR_POLY  16'hB400 Galois feedback mask (maximal-length)
//  SEED       16'h0001 LFSR load value; must be non-zero (elaboration error otherwise)
//  MISR_W     16       signature width
//  MISR_POLY  16'hB400 MISR feedback mask
//  CNT_W      16       pattern-count width
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  start          in   1       1-cycle pulse; starts a session (ignored unless IDLE or DONE)
//  num_patterns   in   CNT_W   patterns to apply; sampled on start
//  golden_sig     in   MISR_W  expected signature; sampled on start
//  pattern_o      out  PI_W    CUT inputs = lfsr[PI_W-1:0]
//  pattern_valid  out  1       high in RUN; CUT response is captured in the same cycle
//  response_i     in   PO_W    CUT outputs (combinational from pattern_o)
//  busy           out  1       high in LOAD, RUN, CMP
//  done           out  1       level; high in DONE until next start or rst
//  pass           out  1       valid while done; 1 = signature == golden_sig
//  signature      out  MISR_W  current MISR contents
// BEHAVIOUR
//  Reset: state=IDLE; lfsr=SEED; misr=0; cnt=0; every output 0, except pattern_o=SEED[PI_W-1:0].
//  Galois step: s' = (s >> 1) ^ (s[0] ? POLY : 0).
//  MISR step:   m' = gstep(m) ^ {zero-extend response_i}.
//  FSM:
//   IDLE/DONE --start--> LOAD.
//    On start: latch num_patterns and golden_sig; clear done and pass.
//   LOAD (1 cycle): lfsr<=SEED; misr<=0; cnt<=latched count.
//    Go to CMP if count==0, else RUN.
//   RUN: each cycle, pattern_valid=1, misr<=MISR step, lfsr<=Galois step, cnt<=cnt-1.
//    When cnt==1, go to CMP.
//    First applied pattern is SEED; the k-th RUN cycle applies the k-th LFSR state.
//   CMP (1 cycle): pass<=(misr==golden_sig); go to DONE.
//   DONE: done=1; pass and signature hold; LFSR frozen.
//  Latency: start -> done = N+3 cycles (start edge, LOAD, N RUN cycles, CMP).
//   N=0 gives 3 cycles; pass is then (0==golden_sig).
//  start during LOAD/RUN/CMP is ignored; no restart mid-session.
//  rst mid-session: next cycle is IDLE with reset values; no partial done/pass.
//  LFSR period: 2^LFSR_W-1. Counts beyond the period wrap the pattern sequence (legal, no error).
//  CNT_W arithmetic is unsigned; the counter never underflows (exit at cnt==1).
// STRUCTURE
//  lbist_pkg: state enum {IDLE,LOAD,RUN,CMP,DONE}, default polynomial/seed constants, gstep function.
//  Sub-module galois_shreg #(W,POLY): load, enable, data_in (zero for LFSR use).
//   Instantiated twice: once as the LFSR, once as the MISR.
//  Top level: FSM, counter, compare register.
// TESTING (config LFSR_W=MISR_W=4, POLY=4'hC, SEED=4'h1, PI_W=4, PO_W=1)
//  start, N=15 -> pattern_o sequence 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2; done at cycle 18.
//  response_i tied 0, N=5, golden=0 -> signature=0, pass=1.
//  response_i tied 1, N=3, golden=4'hB -> signature 1,D,B; pass=1.
//   Same run with golden=4'hA -> pass=0.
//  N=0, golden=0 -> no pattern_valid; done 3 cycles after start; pass=1.
//  rst asserted in 3rd RUN cycle -> IDLE next cycle, all outputs at reset values.
//   start during RUN is ignored; a following start from DONE re-runs with an identical signature.

Source files
------------

// File: rtl/lbist_pkg.sv
// rtl/lbist_pkg.sv - shared state encoding, default constants and Galois step helper
package lbist_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CMP, DONE} state_t;

  // Widest register the step helper supports
  localparam int GS_MAX_W = 64;

  localparam logic [15:0] DEF_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'h0001;

  // One Galois shift: right shift, fold the polynomial in when the LSB drops out
  function automatic logic [GS_MAX_W-1:0] gstep(input logic [GS_MAX_W-1:0] s,
                                                input logic [GS_MAX_W-1:0] poly);
    gstep = (s >> 1) ^ (s[0] ? poly : {GS_MAX_W{1'b0}});
  endfunction

endpackage

// File: rtl/lbist_engine_galois_shreg.sv
// rtl/lbist_engine_galois_shreg.sv - Galois shift register shared by the pattern generator and the MISR
module galois_shreg
  import lbist_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = W'(DEF_POLY),
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  // Load wins over stepping; data_i is XORed into the stepped value (zero for the LFSR)
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = INIT;
    end else if (en_i) begin
      q_d = W'(gstep(GS_MAX_W'(q_q), GS_MAX_W'(POLY))) ^ data_i;
    end
  end

  // State register, reset to the load value
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= INIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lbist_engine.sv
// rtl/lbist_engine.sv - logic-BIST session controller: LFSR patterns, MISR compaction, golden compare
module lbist_engine
  import lbist_pkg::*;
#(
  parameter int                PI_W      = 6,
  parameter int                PO_W      = 1,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(DEF_POLY),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_POLY),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [MISR_W-1:0] golden_sig,
  output logic [PI_W-1:0]   pattern_o,
  output logic              pattern_valid,
  input  logic [PO_W-1:0]   response_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  // Reject configurations the datapath cannot honour
  if (SEED == '0) begin : g_bad_seed
    $error("lbist_engine: SEED must be non-zero");
  end
  if (PI_W > LFSR_W || PO_W > MISR_W) begin : g_bad_width
    $error("lbist_engine: PI_W/PO_W exceed LFSR_W/MISR_W");
  end
  if (LFSR_W > GS_MAX_W || MISR_W > GS_MAX_W) begin : g_too_wide
    $error("lbist_engine: register wider than the step helper");
  end

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, num_q;
  logic [MISR_W-1:0] golden_q, misr_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              pass_q, done_q, busy_q, valid_q;
  logic              step_en, reload;
  logic              lfsr_unused;

  assign reload  = (state_q == LOAD);
  assign step_en = (state_q == RUN);

  galois_shreg #(.W(LFSR_W), .POLY(LFSR_POLY), .INIT(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (reload),
    .en_i   (step_en),
    .data_i ({LFSR_W{1'b0}}),
    .q_o    (lfsr_q)
  );

  galois_shreg #(.W(MISR_W), .POLY(MISR_POLY), .INIT({MISR_W{1'b0}})) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (reload),
    .en_i   (step_en),
    .data_i (MISR_W'(response_i)),
    .q_o    (misr_q)
  );

  // LFSR bits above the CUT input width only feed the sequence itself
  assign lfsr_unused = ^(lfsr_q >> PI_W);

  // Session FSM with pattern counter, latched operands and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_q    <= num_patterns;
            golden_q <= golden_sig;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          cnt_q <= num_q;
          if (num_q == '0) begin
            state_q <= CMP;
          end else begin
            valid_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            valid_q <= 1'b0;
            state_q <= CMP;
          end
        end
        CMP: begin
          pass_q  <= (misr_q == golden_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pattern_o     = lfsr_q[PI_W-1:0];
  assign pattern_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign signature     = misr_q;

endmodule

// File: tb/tb_lbist_engine.sv
// tb/tb_lbist_engine.sv - table-driven bench for lbist_engine in a 4-bit configuration
module tb_lbist_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_patterns;
  logic [3:0] golden_sig;
  logic [3:0] pattern_o;
  logic       pattern_valid;
  logic [0:0] response_i;
  logic       busy, done, pass;
  logic [3:0] signature;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] n;
    logic       resp;
    logic [3:0] golden;
    int         mid;
    logic [3:0] sig;
    logic       pass;
    int         cyc;
  } vec_t;

  vec_t vecs [10];

  logic [3:0] pat_tab [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                               4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  lbist_engine #(
    .PI_W(4), .PO_W(1), .LFSR_W(4), .LFSR_POLY(4'hC), .SEED(4'h1),
    .MISR_W(4), .MISR_POLY(4'hC), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_patterns  (num_patterns),
    .golden_sig    (golden_sig),
    .pattern_o     (pattern_o),
    .pattern_valid (pattern_valid),
    .response_i    (response_i),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pattern"}, pattern_o, 4'h1);
    chk({tag, "_valid"}, pattern_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_sig"}, signature, 4'h0);
  endtask

  // Runs one session from a negedge; counts negedges from the start edge until done
  task automatic run(input vec_t v, input string tag);
    int cyc;
    int k;
    num_patterns = v.n;
    golden_sig   = v.golden;
    response_i   = v.resp;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    k     = 0;
    chk({tag, "_load_busy"}, busy, 1);
    chk({tag, "_load_done"}, done, 0);
    chk({tag, "_load_pass"}, pass, 0);
    while (!done && cyc < 200) begin
      if (pattern_valid) begin
        chk({tag, "_pattern"}, pattern_o, pat_tab[k % 15]);
        k++;
      end
      if (cyc == v.mid) begin
        start        = 1'b1;
        num_patterns = 8'd2;
        golden_sig   = 4'hF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 200) begin
      bad++;
      total++;
      $display("FAIL %s_timeout actual=no_done required=done", tag);
    end
    chk({tag, "_latency"}, cyc, v.cyc);
    chk({tag, "_nvalid"}, k, v.n);
    chk({tag, "_sig"}, signature, v.sig);
    chk({tag, "_pass"}, pass, v.pass);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'd15, 1'b0, 4'h0, 0, 4'h0, 1'b1, 18};
    vecs[1] = '{8'd5,  1'b0, 4'h0, 0, 4'h0, 1'b1, 8};
    vecs[2] = '{8'd3,  1'b1, 4'hB, 0, 4'hB, 1'b1, 6};
    vecs[3] = '{8'd3,  1'b1, 4'hA, 0, 4'hB, 1'b0, 6};
    vecs[4] = '{8'd0,  1'b0, 4'h0, 0, 4'h0, 1'b1, 3};
    vecs[5] = '{8'd0,  1'b1, 4'h5, 0, 4'h0, 1'b0, 3};
    vecs[6] = '{8'd1,  1'b1, 4'h1, 0, 4'h1, 1'b1, 4};
    vecs[7] = '{8'd17, 1'b0, 4'h0, 0, 4'h0, 1'b1, 20};
    vecs[8] = '{8'd4,  1'b1, 4'h8, 3, 4'h8, 1'b1, 7};
    vecs[9] = '{8'd4,  1'b1, 4'h8, 0, 4'h8, 1'b1, 7};

    rst          = 1'b1;
    start        = 1'b0;
    num_patterns = '0;
    golden_sig   = '0;
    response_i   = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("idle");

    for (int i = 0; i < 10; i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the third RUN cycle: next cycle must be IDLE with reset values
    num_patterns = 8'd10;
    golden_sig   = 4'h0;
    response_i   = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_run", pattern_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done, 0);

    run(vecs[2], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
